// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_pkg: state encoding, opcode and ALUOp constants for the multicycle LEGv8 control FSM
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_FAULT  = 4'd15
    } state_t;

    localparam logic [10:0] OP_LDUR     = 11'b11111000010;
    localparam logic [10:0] OP_STUR     = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ_MSB8 = 8'b10110100;
    localparam logic [10:0] OP_ADD      = 11'b10001011000;
    localparam logic [10:0] OP_SUB      = 11'b11001011000;
    localparam logic [10:0] OP_AND      = 11'b10001010000;
    localparam logic [10:0] OP_ORR      = 11'b10101010000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    // Where DECODE goes for a given opcode; anything unrecognised traps.
    function automatic state_t decode_op(input logic [10:0] op);
        if (op == OP_LDUR || op == OP_STUR)
            return S_MEMADR;
        if (op[10:3] == OP_CBZ_MSB8)
            return S_BRANCH;
        if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR)
            return S_EXEC;
        return S_FAULT;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control bus between the multicycle FSM and the LEGv8 datapath
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [10:0]      Op;
    logic             Zero;
    logic             MemReady;
    logic             PCWrite;
    logic             PCSrc;
    logic             IRWrite;
    logic             IorD;
    logic             Reg2Loc;
    logic             ALUSrc;
    logic [1:0]       ALUOp;
    logic             MemRead;
    logic             MemWrite;
    logic             MemtoReg;
    logic             RegWrite;
    logic             Fault;
    logic [CNT_W-1:0] InstrCount;
    logic [3:0]       State;

    modport master (
        input  Op, Zero, MemReady,
        output PCWrite, PCSrc, IRWrite, IorD, Reg2Loc, ALUSrc, ALUOp,
               MemRead, MemWrite, MemtoReg, RegWrite, Fault, InstrCount, State
    );

    modport slave (
        output Op, Zero, MemReady,
        input  PCWrite, PCSrc, IRWrite, IorD, Reg2Loc, ALUSrc, ALUOp,
               MemRead, MemWrite, MemtoReg, RegWrite, Fault, InstrCount, State
    );
endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// mem_wait_timer: counts cycles a memory state has waited for MemReady and flags the last allowed one
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign expired_o = cnt_q == W'(TIMEOUT - 1);

    // Saturate at the last allowed value; the FSM leaves the state on that cycle anyway.
    always_comb cnt_d = clear_i ? '0 : (en_i && !expired_o) ? cnt_q + 1'b1 : cnt_q;

    // Counter register.
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: LEGv8 multicycle control FSM with memory-wait timeout, retire counter and sticky fault
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input logic              clk,
    input logic              reset,
    multicycle_ctrl_if.master bus
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire, wait_st, tmo, tmr_clr, tmr_en;

    assign wait_st = state_q inside {S_FETCH, S_MEMRD, S_MEMWR};
    assign tmr_en  = wait_st && !bus.MemReady;
    assign tmr_clr = state_d != state_q && state_d inside {S_FETCH, S_MEMRD, S_MEMWR};
    assign cnt_d   = cnt_q + CNT_W'(retire);

    assign bus.State      = state_q;
    assign bus.InstrCount = cnt_q;

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (tmr_clr),
        .en_i      (tmr_en),
        .expired_o (tmo)
    );

    // Next state, Moore/Mealy control outputs and retire strobe.
    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        bus.PCWrite  = 1'b0;
        bus.PCSrc    = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.IorD     = 1'b0;
        bus.Reg2Loc  = 1'b0;
        bus.ALUSrc   = 1'b0;
        bus.ALUOp    = ALUOP_ADD;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.RegWrite = 1'b0;
        bus.Fault    = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.IRWrite = bus.MemReady;
                bus.PCWrite = bus.MemReady;
                state_d     = bus.MemReady ? S_DECODE : tmo ? S_FAULT : S_FETCH;
            end
            S_DECODE: state_d = decode_op(bus.Op);
            S_MEMADR: begin
                bus.ALUSrc  = 1'b1;
                bus.Reg2Loc = bus.Op == OP_STUR;
                state_d     = bus.Op == OP_STUR ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                bus.ALUSrc  = 1'b1;
                state_d     = bus.MemReady ? S_MEMWB : tmo ? S_FAULT : S_MEMRD;
            end
            S_MEMWB: begin
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                bus.ALUSrc   = 1'b1;
                bus.Reg2Loc  = 1'b1;
                retire       = bus.MemReady;
                state_d      = bus.MemReady ? S_FETCH : tmo ? S_FAULT : S_MEMWR;
            end
            S_EXEC: begin
                bus.ALUOp = ALUOP_RTYPE;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                bus.ALUOp    = ALUOP_RTYPE;
                bus.RegWrite = 1'b1;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                bus.Reg2Loc = 1'b1;
                bus.ALUOp   = ALUOP_PASSB;
                bus.PCSrc   = 1'b1;
                bus.PCWrite = bus.Zero;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_FAULT: bus.Fault = 1'b1;
            default: state_d = S_FAULT;
        endcase
    end

    // State and retired-instruction counter registers.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table, directed and randomized checks of multicycle_ctrl against a per-instruction trace model
module tb_multicycle_ctrl;
    localparam int IDLE = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMRD = 4, MEMWB = 5;
    localparam int MEMWR = 6, EXEC = 7, ALUWB = 8, BRANCH = 9, FAULT = 15;
    localparam logic [10:0] LDUR = 11'b11111000010, STUR = 11'b11111000000;
    localparam logic [10:0] ADD = 11'b10001011000, SUB = 11'b11001011000;
    localparam logic [10:0] ANDI = 11'b10001010000, ORR = 11'b10101010000;
    localparam logic [10:0] CBZ = 11'b10110100101, BAD = 11'b11111111111;

    typedef struct {
        logic [10:0] op;
        logic        mr;
        logic        z;
        logic [3:0]  st;
        logic [12:0] ctl;
        logic [31:0] cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] op = '0;
    logic        mr = 1'b0;
    logic        zero = 1'b0;
    logic        sel = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          m_cnt = 0;
    bit          m_fault = 0;
    vec_t        q[$];

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(32)) bus_a ();
    multicycle_ctrl_if #(.CNT_W(32)) bus_b ();

    assign bus_a.Op = op;
    assign bus_a.MemReady = mr;
    assign bus_a.Zero = zero;
    assign bus_b.Op = op;
    assign bus_b.MemReady = mr;
    assign bus_b.Zero = zero;

    multicycle_ctrl #(.TIMEOUT(15), .CNT_W(32)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    multicycle_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    wire [12:0] ctl_a = {bus_a.PCWrite, bus_a.PCSrc, bus_a.IRWrite, bus_a.IorD, bus_a.Reg2Loc, bus_a.ALUSrc,
                         bus_a.ALUOp, bus_a.MemRead, bus_a.MemWrite, bus_a.MemtoReg, bus_a.RegWrite, bus_a.Fault};
    wire [12:0] ctl_b = {bus_b.PCWrite, bus_b.PCSrc, bus_b.IRWrite, bus_b.IorD, bus_b.Reg2Loc, bus_b.ALUSrc,
                         bus_b.ALUOp, bus_b.MemRead, bus_b.MemWrite, bus_b.MemtoReg, bus_b.RegWrite, bus_b.Fault};
    wire [12:0] act_ctl = sel ? ctl_b : ctl_a;
    wire [3:0]  act_st  = sel ? bus_b.State : bus_a.State;
    wire [31:0] act_cnt = sel ? bus_b.InstrCount : bus_a.InstrCount;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [10:0] rop();
        return 11'($urandom);
    endfunction

    // 0 illegal, 1 load, 2 store, 3 cbz, 4 r-type
    function automatic int cls(input logic [10:0] o);
        if (o == LDUR) return 1;
        if (o == STUR) return 2;
        if (o[10:3] == 8'hB4) return 3;
        if (o == ADD || o == SUB || o == ANDI || o == ORR) return 4;
        return 0;
    endfunction

    // Control word expected in a given state: {PCWrite,PCSrc,IRWrite,IorD,Reg2Loc,ALUSrc,ALUOp,MemRead,MemWrite,MemtoReg,RegWrite,Fault}
    function automatic logic [12:0] exp_ctl(input int st, input logic [10:0] o, input logic r, input logic z);
        logic pcw = 0, pcs = 0, irw = 0, iord = 0, r2l = 0, alus = 0, memr = 0, memw = 0, m2r = 0, rw = 0, flt = 0;
        logic [1:0] aluop = 2'b00;
        case (st)
            FETCH:  begin memr = 1; pcw = r; irw = r; end
            MEMADR: begin alus = 1; r2l = (o == STUR); end
            MEMRD:  begin memr = 1; iord = 1; alus = 1; end
            MEMWB:  begin m2r = 1; rw = 1; end
            MEMWR:  begin memw = 1; iord = 1; alus = 1; r2l = 1; end
            EXEC:   aluop = 2'b10;
            ALUWB:  begin aluop = 2'b10; rw = 1; end
            BRANCH: begin r2l = 1; aluop = 2'b01; pcs = 1; pcw = z; end
            FAULT:  flt = 1;
            default: ;
        endcase
        return {pcw, pcs, irw, iord, r2l, alus, aluop, memr, memw, m2r, rw, flt};
    endfunction

    task automatic push(input int st, input logic [10:0] o, input logic r, input logic z, input bit ret);
        vec_t v;
        v.op = o;
        v.mr = r;
        v.z = z;
        v.st = 4'(st);
        v.ctl = exp_ctl(st, o, r, z);
        v.cnt = 32'(m_cnt);
        q.push_back(v);
        if (ret) m_cnt++;
    endtask

    // A memory state that sees w not-ready cycles before MemReady; ok=0 means the wait timed out.
    task automatic wait_in(input int st, input int w, input int to, input bit ret, output bit ok);
        int n = w < to ? w : to;
        for (int i = 0; i < n; i++) push(st, rop(), 1'b0, rb(), 0);
        ok = w < to;
        if (ok) push(st, rop(), 1'b1, rb(), ret);
    endtask

    // Expected cycle trace of one instruction, starting at FETCH.
    task automatic gen(input logic [10:0] o, input int fw, input int mw, input logic z, input int nf);
        int to = sel ? 4 : 15;
        bit ok;
        wait_in(FETCH, fw, to, 0, ok);
        if (ok) begin
            push(DECODE, o, rb(), rb(), 0);
            case (cls(o))
                1: begin
                    push(MEMADR, o, rb(), rb(), 0);
                    wait_in(MEMRD, mw, to, 0, ok);
                    if (ok) push(MEMWB, rop(), rb(), rb(), 1);
                end
                2: begin
                    push(MEMADR, o, rb(), rb(), 0);
                    wait_in(MEMWR, mw, to, 1, ok);
                end
                3: push(BRANCH, rop(), rb(), z, 1);
                4: begin
                    push(EXEC, rop(), rb(), rb(), 0);
                    push(ALUWB, rop(), rb(), rb(), 1);
                end
                default: ok = 0;
            endcase
        end
        if (!ok) begin
            m_fault = 1;
            repeat (nf) push(FAULT, rop(), rb(), rb(), 0);
        end
    endtask

    task automatic run_vec(input vec_t v);
        op = v.op;
        mr = v.mr;
        zero = v.z;
        @(negedge clk);
        chk("state", act_st, v.st);
        chk("ctl", act_ctl, v.ctl);
        chk("count", act_cnt, v.cnt);
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input int n);
        int m = n < q.size() ? n : q.size();
        for (int i = 0; i < m; i++) run_vec(q[i]);
        q.delete();
    endtask

    // Asynchronous reset: outputs must clear before any clock edge; release just after a rising edge.
    task automatic rst_seq();
        mr = 1'b1;
        reset = 1'b0;
        #1;
        chk("rst_state", act_st, 0);
        chk("rst_ctl", act_ctl, 0);
        chk("rst_count", act_cnt, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_cnt = 0;
        m_fault = 0;
        push(IDLE, rop(), rb(), rb(), 0);
    endtask

    initial begin
        vec_t tbl[6];
        tbl[0] = '{op: ADD, mr: 1'b1, z: 1'b0, st: 4'd0, ctl: 13'b0000000000000, cnt: 32'd0};
        tbl[1] = '{op: ADD, mr: 1'b1, z: 1'b0, st: 4'd1, ctl: 13'b1010000010000, cnt: 32'd0};
        tbl[2] = '{op: ADD, mr: 1'b1, z: 1'b0, st: 4'd2, ctl: 13'b0000000000000, cnt: 32'd0};
        tbl[3] = '{op: ADD, mr: 1'b1, z: 1'b0, st: 4'd7, ctl: 13'b0000001000000, cnt: 32'd0};
        tbl[4] = '{op: ADD, mr: 1'b1, z: 1'b0, st: 4'd8, ctl: 13'b0000001000010, cnt: 32'd0};
        tbl[5] = '{op: ADD, mr: 1'b1, z: 1'b0, st: 4'd1, ctl: 13'b1010000010000, cnt: 32'd1};
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) run_vec(tbl[i]);
        rst_seq();
        gen(ADD, 0, 0, 1'b0, 0);
        gen(LDUR, 1, 3, 1'b0, 0);
        gen(CBZ, 0, 0, 1'b1, 0);
        gen(CBZ, 2, 0, 1'b0, 0);
        gen(BAD, 0, 0, 1'b0, 20);
        apply(1000);
        rst_seq();
        gen(ADD, 0, 0, 1'b0, 0);
        gen(STUR, 0, 10, 1'b0, 0);
        apply(10);
        mr = 1'b0;
        #1;
        chk("pre_rst_memwrite", {31'd0, act_ctl[3]}, 1);
        rst_seq();
        gen(ADD, 0, 0, 1'b0, 0);
        apply(1000);
        sel = 1'b1;
        rst_seq();
        gen(ADD, 6, 0, 1'b0, 3);
        apply(1000);
        rst_seq();
        gen(ADD, 3, 0, 1'b0, 0);
        gen(STUR, 0, 3, 1'b0, 0);
        gen(LDUR, 0, 4, 1'b0, 3);
        apply(1000);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            rst_seq();
            repeat (40) begin
                logic [10:0] o;
                int to = sel ? 4 : 15;
                int fw = $urandom_range(0, 7) == 0 ? $urandom_range(0, to + 1) : $urandom_range(0, 3);
                int mw = $urandom_range(0, 7) == 0 ? $urandom_range(0, to + 1) : $urandom_range(0, 3);
                case ($urandom_range(0, 7))
                    0: o = LDUR;
                    1: o = STUR;
                    2: o = {8'hB4, 3'($urandom)};
                    3: o = ADD;
                    4: o = SUB;
                    5: o = ANDI;
                    6: o = ORR;
                    default: begin
                        o = rop();
                        while (cls(o) != 0) o = rop();
                    end
                endcase
                gen(o, fw, mw, rb(), 3);
                apply(1000);
                if (m_fault) rst_seq();
            end
        end
        apply(1000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Control FSM that sequences a multicycle LEGv8 datapath over a shared instruction/data memory with variable latency.
Supported instructions: LDUR, STUR, CBZ, ADD, SUB, AND, ORR.
- Per state, it drives datapath selects and the register-file/memory strobes.
- It waits on the memory ready handshake, with a timeout.
- It counts retired instructions.
- It traps illegal opcodes and memory timeouts into a sticky fault state.

Parameters:
TIMEOUT, 15, max cycles spent in one memory state waiting for MemReady before faulting (>=1)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
Op  in  11  opcode field from instruction register (valid from DECODE onward)
Zero  in  1  ALU zero flag
MemReady  in  1  memory completes current access this cycle
PCWrite  out  1  PC load enable
PCSrc  out  1  0 = PC+4, 1 = branch target
IRWrite  out  1  instruction register load
IorD  out  1  memory address: 0 = PC, 1 = ALU result
Reg2Loc  out  1  second read register select (1 = Rt)
ALUSrc  out  1  0 = register, 1 = sign-extended immediate
ALUOp  out  2  00 add (ld/st), 01 pass-B (CBZ), 10 R-type funct
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
MemtoReg  out  1  write-back from memory data
RegWrite  out  1  register file write enable
Fault  out  1  sticky fault indicator
InstrCount  out  CNT_W  retired instructions
State  out  4  current state encoding (debug)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; wait counter=0; InstrCount=0; all control outputs 0; Fault=0.
- IDLE: all outputs 0; next state FETCH, unconditionally.
- FETCH:
  - Outputs: MemRead=1, IorD=0.
  - On MemReady=1: IRWrite=1 and PCWrite=1 (PCSrc=0) in that same cycle; next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: all strobes 0; classifies Op.
  - LDUR 11111000010 -> MEMADR.
  - STUR 11111000000 -> MEMADR.
  - CBZ 10110100xxx -> BRANCH.
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> EXEC.
  - Anything else -> FAULT.
- MEMADR: ALUSrc=1, ALUOp=00, Reg2Loc=1 if STUR. Next state: MEMRD for LDUR, MEMWR for STUR.
- MEMRD: MemRead=1, IorD=1, ALUSrc=1. MemReady=1 -> MEMWB; otherwise stay.
- MEMWB: MemtoReg=1, RegWrite=1; next FETCH; retire.
- MEMWR: MemWrite=1, IorD=1, ALUSrc=1, Reg2Loc=1. MemReady=1 -> FETCH and retire; otherwise stay.
- EXEC: ALUOp=10, ALUSrc=0; next ALUWB.
- ALUWB: RegWrite=1, ALUOp=10; next FETCH; retire.
- BRANCH: Reg2Loc=1, ALUOp=01, PCSrc=1, PCWrite=Zero (Mealy); next FETCH; retire.
- FAULT: Fault=1, all other strobes 0, InstrCount frozen. Exit only by reset.
- Op is sampled only in DECODE and MEMADR; it is don't-care elsewhere.
- Retire: InstrCount += 1 on the clock edge leaving a retiring state; wraps modulo 2^CNT_W.
- Wait timer:
  - Cleared on entry to FETCH, MEMRD and MEMWR.
  - Increments each cycle spent in one of those states with MemReady=0.
  - MemReady=0 while timer==TIMEOUT-1 -> next state FAULT.
  - MemReady=1 in that same cycle wins (normal completion).
  - A state therefore waits at most TIMEOUT cycles.
- Latency with MemReady tied to 1:
  - R-type: 4 cycles (FETCH, DECODE, EXEC, ALUWB).
  - LDUR: 5 cycles.
  - STUR: 4 cycles.
  - CBZ: 3 cycles.
- Outputs are combinational from state (plus MemReady/Zero where stated). There is no output register and no extra latency.
- MemRead and MemWrite are never asserted together.
- State encoding (State port): IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, FAULT=15.

Decomposition:
- Package multicycle_pkg:
  - state_t enum with the encoding above.
  - Opcode constants OP_LDUR, OP_STUR, OP_CBZ_MSB8, OP_ADD, OP_SUB, OP_AND, OP_ORR.
  - ALUOp constants ALUOP_ADD=00, ALUOP_PASSB=01, ALUOP_RTYPE=10.
- Sub-module mem_wait_timer: clear/enable inputs, parameter TIMEOUT, expired output. Holds the timeout counter.
- The FSM, output decode and retire counter stay in multicycle_ctrl.

Test Plan:
1. reset=0 for 3 cycles, then 1; Op=10001011000, MemReady=1 -> State sequence 0,1,2,7,8,1. RegWrite=1 only in the ALUWB cycle, ALUOp=10 in EXEC/ALUWB, InstrCount 0->1.
2. LDUR Op=11111000010, MemReady low for 3 cycles in MEMRD -> MemRead=1, IorD=1 for 4 cycles. Exactly one MemtoReg=RegWrite=1 cycle follows. InstrCount increments by 1.
3. CBZ Op=10110100101:
   - Zero=1 -> BRANCH cycle shows PCWrite=1, PCSrc=1, Reg2Loc=1, ALUOp=01.
   - Repeat with Zero=0 -> PCWrite=0.
   - Both increment InstrCount.
4. Op=11111111111 -> FAULT (State=15) on the cycle after DECODE. Fault=1 and all strobes 0, held for 20 cycles under random MemReady/Op. Pulsing reset low -> IDLE, Fault=0, InstrCount=0.
5. TIMEOUT=4:
   - MemReady=0 in FETCH -> exactly 4 FETCH cycles, then FAULT.
   - Rerun with MemReady=1 on the 4th FETCH cycle -> DECODE, no fault.
6. Assert reset mid-MEMWR (asynchronously, between edges) -> MemWrite and all outputs drop to 0 without waiting for a clock edge; InstrCount=0. After release -> IDLE, then FETCH.
